// File: rtl/adder_arbiter.sv
// Round-robin arbiter that time-shares one single-precision adder among NUM_REQ
// requesters, with a watchdog that aborts an operation whose result never arrives.
module adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     resp_done,
  output logic [31:0]            resp_data,
  output logic                   resp_err,
  output logic                   add_load,
  output logic [31:0]            add_a,
  output logic [31:0]            add_b,
  input  logic [31:0]            add_result,
  input  logic                   add_result_ready,
  output logic                   add_result_ack,
  output logic                   busy,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   err_sticky,
  input  logic                   err_clr
);

  localparam int CNT_W = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_ACK  = 2'd3;

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_rr;
  logic [IDX_W-1:0] r_gnt;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_data;
  logic             r_err;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic             r_err_sticky;

  logic             w_any;
  logic [IDX_W-1:0] w_gnt;
  logic [31:0]      w_opa;
  logic [31:0]      w_opb;

  // Scan from farthest to nearest so the nearest set bit after rr wins.
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req[(int'(r_rr) + k) % NUM_REQ]) begin
        w_any = 1'b1;
        w_gnt = IDX_W'((int'(r_rr) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    w_opa = '0;
    w_opb = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == w_gnt) begin
        w_opa = req_a[32*i +: 32];
        w_opb = req_b[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_rr         <= IDX_W'(NUM_REQ-1);
      r_gnt        <= '0;
      r_cnt        <= '0;
      r_data       <= '0;
      r_err        <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_err_sticky <= 1'b0;
    end else begin
      if (err_clr) r_err_sticky <= 1'b0;
      case (r_state)
        S_IDLE: if (w_any) begin
          r_gnt   <= w_gnt;
          r_rr    <= w_gnt;
          r_a     <= w_opa;
          r_b     <= w_opb;
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (add_result_ready) begin
            r_data  <= add_result;
            r_err   <= 1'b0;
            r_state <= S_ACK;
          end else if (r_cnt == CNT_W'(TIMEOUT-1)) begin
            // Clear request in the same cycle beats the sticky set.
            r_data  <= '0;
            r_err   <= 1'b1;
            if (!err_clr) r_err_sticky <= 1'b1;
            r_state <= S_ACK;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_ACK:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_done
    assign resp_done[i] = (r_state == S_ACK) && (r_gnt == IDX_W'(i));
  end

  assign resp_data      = r_data;
  assign resp_err       = r_err;
  assign add_load       = (r_state == S_LOAD);
  assign add_result_ack = (r_state == S_ACK);
  assign busy           = (r_state != S_IDLE);
  assign add_a          = r_a;
  assign add_b          = r_b;
  assign grant_idx      = r_gnt;
  assign err_sticky     = r_err_sticky;

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one single-precision adder among NUM_REQ requesters.
- Drives the adder's load / result_ready / result_ack handshake and steers the granted requester's operands onto the adder.
- Returns the result to the winning requester with a one-cycle done pulse.
- A watchdog recovers from an adder that never raises result_ready.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, 2, grant index width; must satisfy 2**IDX_W >= NUM_REQ.
- TIMEOUT, 16, maximum cycles spent in WAIT before aborting (>= 4).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request; requester holds it until its done pulse.
- req_a  in  32*NUM_REQ  operand A, requester i on bits [32i+31:32i].
- req_b  in  32*NUM_REQ  operand B, same packing.
- resp_done  out  NUM_REQ  one-hot, one-cycle completion pulse.
- resp_data  out  32  result; valid while any resp_done bit is high.
- resp_err  out  1  high together with resp_done when the operation timed out.
- add_load  out  1  load strobe to the adder.
- add_a  out  32  adder Number1.
- add_b  out  32  adder Number2.
- add_result  in  32  adder Result.
- add_result_ready  in  1  adder result_ready.
- add_result_ack  out  1  adder result_ack.
- busy  out  1  high in any state other than IDLE.
- grant_idx  out  IDX_W  index of the current or last granted requester.
- err_sticky  out  1  set on any timeout.
- err_clr  in  1  synchronous clear of err_sticky.

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE, rr pointer=NUM_REQ-1, grant_idx=0, timeout counter=0.
  - All outputs 0: resp_done, resp_data, resp_err, add_load, add_a, add_b, add_result_ack, busy, err_sticky.
  - Reset during an operation abandons it: no done pulse is issued, and the adder is reset by the same net.
- FSM states: IDLE, LOAD, WAIT, ACK.
- IDLE:
  - If any req bit is set, grant the first set bit searching cyclically from rr+1.
  - Register grant_idx, set rr=grant_idx, go to LOAD.
  - If no req is set, stay in IDLE.
- LOAD:
  - add_load=1 for exactly one cycle.
  - add_a/add_b = operands of grant_idx, held stable from LOAD through ACK.
  - Timeout counter cleared. Next state WAIT.
- WAIT:
  - add_load=0; counter increments each cycle.
  - If add_result_ready=1: register resp_data=add_result, resp_err=0, go to ACK.
  - Else, if counter reaches TIMEOUT-1: resp_data=0, resp_err=1, err_sticky=1, go to ACK.
- ACK:
  - add_result_ack=1 and resp_done[grant_idx]=1, both for exactly one cycle.
  - resp_err is meaningful only in this cycle. Next state IDLE.
- Outputs are registered or decoded from state only; there is no combinational path from req or add_result_ready to any output.
- Latency with the current adder (result_ready 2 cycles after the load edge):
  - grant edge → LOAD → load edge → WAIT.
  - result_ready seen 2 edges later, captured on the following edge.
  - resp_done high in the cycle starting 4 edges after the grant edge.
  - Minimum issue interval is 5 cycles per operation.
- Fairness:
  - A requester that keeps req high after its done is re-arbitrated behind all other active requesters.
  - Worst-case wait is (NUM_REQ-1) operations.
- If a requester drops req after being granted, the operation still completes and resp_done still pulses for that index.
- req changes while busy affect only the next IDLE arbitration.
- The adder returns to its input state on the ack edge, so LOAD may follow IDLE immediately.
- err_clr has priority over a simultaneous timeout set: clear wins, and resp_err still pulses.
- The counter does not wrap, because WAIT exits at TIMEOUT-1.

Test Plan:
- Single request: req=0001, a=0x00000000, b=0x40490FDB → one add_load pulse; resp_done=0001 exactly 4 edges after the grant edge; resp_data=0x40490FDB; resp_err=0.
- Contention: req=1111 held, a_i=0, b_i=0x3F800000+i → grants in order 0,1,2,3,0; one done per operation; each resp_data equals its own b_i.
- Rotation after partial service: req=0101 after rr=0 → grant 2 then 0; req[1]/req[3] never get done pulses.
- Timeout: stub adder never raises ready, TIMEOUT=16 → resp_done with resp_err=1 and resp_data=0, 17 edges after LOAD; err_sticky=1; err_clr=1 → err_sticky=0 next cycle.
- Reset mid-operation: reset low during WAIT → all outputs 0 immediately; after release with req=0010, grant_idx=1 and normal completion.
- Request withdrawal: req[2] dropped during WAIT → resp_done[2] still pulses; next IDLE sees no request and stays idle with busy=0.
